pixel_readout_ctrl: RTL and testbench



---
 rtl/pixel_readout_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for the 4-pixel array: ERASE -> EXPOSE -> CONVERT (ramped) -> READ,
// then streams the four captured pixel codes out on a valid/ready byte interface.
module pixel_readout_ctrl #(
    parameter int ERASE_CYC  = 5,
    parameter int EXPOSE_CYC = 255,
    parameter int RAMP_STEPS = 255,
    parameter int READ_CYC   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    output logic        ERASE,
    output logic        EXPOSE,
    output logic        CONVERT,
    output logic        RAMP,
    output logic        READ,
    input  logic [7:0]  DATA1,
    input  logic [7:0]  DATA2,
    input  logic [7:0]  DATA3,
    input  logic [7:0]  DATA4,
    output logic [7:0]  out_data,
    output logic [1:0]  out_idx,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ,
        S_STREAM
    } state_t;

    localparam logic [7:0] ERASE_LAST  = 8'(ERASE_CYC - 1);
    localparam logic [7:0] EXPOSE_LAST = 8'(EXPOSE_CYC - 1);
    localparam logic [7:0] READ_LAST   = 8'(READ_CYC - 1);
    localparam logic [7:0] RAMP_LAST   = 8'(RAMP_STEPS);

    state_t      state_q;
    logic [7:0]  phase_q;
    logic [7:0]  ramp_cnt_q;
    logic        erase_q;
    logic        expose_q;
    logic        convert_q;
    logic        ramp_q;
    logic        read_q;
    logic        busy_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic [1:0]  out_idx_q;
    logic [7:0]  out_data_q;
    logic [15:0] frame_cnt_q;

    logic [7:0]  data_in [4];
    logic [7:0]  buf_q   [4];
    logic        capture_d;
    logic        fire_d;
    logic        restart_d;
    logic [1:0]  idx_next_d;

    assign data_in[0] = DATA1;
    assign data_in[1] = DATA2;
    assign data_in[2] = DATA3;
    assign data_in[3] = DATA4;

    assign capture_d  = (state_q == S_READ) && (phase_q == READ_LAST);
    assign fire_d     = out_valid_q & out_ready;
    assign restart_d  = continuous | start;
    assign idx_next_d = out_idx_q + 2'd1;

    // The array latched on READ's rising edge, so the last READ cycle sees settled codes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                buf_q[gi] <= '0;
            end else if (capture_d) begin
                buf_q[gi] <= data_in[gi];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            ramp_cnt_q  <= '0;
            erase_q     <= 1'b0;
            expose_q    <= 1'b0;
            convert_q   <= 1'b0;
            ramp_q      <= 1'b0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ERASE;
                        erase_q <= 1'b1;
                        busy_q  <= 1'b1;
                        phase_q <= '0;
                    end
                end
                S_ERASE: begin
                    if (phase_q == ERASE_LAST) begin
                        state_q  <= S_EXPOSE;
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                        phase_q  <= '0;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_EXPOSE: begin
                    if (phase_q == EXPOSE_LAST) begin
                        state_q    <= S_CONVERT;
                        expose_q   <= 1'b0;
                        convert_q  <= 1'b1;
                        ramp_q     <= 1'b0;
                        ramp_cnt_q <= '0;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_CONVERT: begin
                    // Low cycle first and last; each low->high counts one ramp edge.
                    if (ramp_q) begin
                        ramp_q <= 1'b0;
                    end else if (ramp_cnt_q == RAMP_LAST) begin
                        state_q   <= S_READ;
                        convert_q <= 1'b0;
                        read_q    <= 1'b1;
                        phase_q   <= '0;
                    end else begin
                        ramp_q     <= 1'b1;
                        ramp_cnt_q <= ramp_cnt_q + 8'd1;
                    end
                end
                S_READ: begin
                    if (phase_q == READ_LAST) begin
                        state_q     <= S_STREAM;
                        read_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= 2'd0;
                        out_last_q  <= 1'b0;
                        out_data_q  <= data_in[0];
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_STREAM: begin
                    if (fire_d) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            if (restart_d) begin
                                state_q <= S_ERASE;
                                erase_q <= 1'b1;
                                phase_q <= '0;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            out_idx_q  <= idx_next_d;
                            out_data_q <= buf_q[idx_next_d];
                            out_last_q <= (idx_next_d == 2'd3);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ERASE     = erase_q;
    assign EXPOSE    = expose_q;
    assign CONVERT   = convert_q;
    assign RAMP      = ramp_q;
    assign READ      = read_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl: default-parameter instance for frame, stall,
// continuous, reset and start-handling checks, plus a minimal-parameter instance for latency.
module tb_pixel_readout_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, continuous, out_ready;
    logic [7:0]  d1, d2, d3, d4;
    logic        ERASE, EXPOSE, CONVERT, RAMP, READ;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last, out_valid, busy;
    logic [15:0] frame_cnt;

    logic        s_start;
    logic        s_ERASE, s_EXPOSE, s_CONVERT, s_RAMP, s_READ;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_idx;
    logic        s_out_last, s_out_valid, s_busy;
    logic [15:0] s_frame_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pixel_readout_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .ERASE(ERASE), .EXPOSE(EXPOSE), .CONVERT(CONVERT), .RAMP(RAMP), .READ(READ),
        .DATA1(d1), .DATA2(d2), .DATA3(d3), .DATA4(d4),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_cnt(frame_cnt)
    );

    pixel_readout_ctrl #(
        .ERASE_CYC(1), .EXPOSE_CYC(1), .RAMP_STEPS(1), .READ_CYC(2)
    ) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .continuous(1'b0),
        .ERASE(s_ERASE), .EXPOSE(s_EXPOSE), .CONVERT(s_CONVERT), .RAMP(s_RAMP), .READ(s_READ),
        .DATA1(8'hA1), .DATA2(8'hB2), .DATA3(8'hC3), .DATA4(8'hD4),
        .out_data(s_out_data), .out_idx(s_out_idx), .out_last(s_out_last),
        .out_valid(s_out_valid), .out_ready(1'b1), .busy(s_busy), .frame_cnt(s_frame_cnt)
    );

    // Cumulative per-cycle observations; the directed sequence works on deltas.
    int   erase_n = 0, expose_n = 0, conv_n = 0, read_n = 0;
    int   ramp_edges = 0, onehot_err = 0;
    logic ramp_prev = 1'b0;
    logic [7:0] bd [$];
    logic [1:0] bi [$];
    logic       bl [$];

    always @(negedge clk) begin
        if (ERASE)   erase_n++;
        if (EXPOSE)  expose_n++;
        if (CONVERT) conv_n++;
        if (READ)    read_n++;
        if (RAMP && !ramp_prev) ramp_edges++;
        ramp_prev = RAMP;
        if (int'(ERASE) + int'(EXPOSE) + int'(CONVERT) + int'(READ) > 1) onehot_err++;
        if (out_valid && out_ready) begin
            bd.push_back(out_data);
            bi.push_back(out_idx);
            bl.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int ramp_goal = 0;

    function automatic bit cond(input int which);
        case (which)
            0:       return out_valid;
            1:       return READ;
            2:       return EXPOSE;
            3:       return !busy;
            4:       return out_valid && out_last;
            5:       return ramp_edges >= ramp_goal;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int maxc, input string tag);
        int  n   = 0;
        bit  hit = 1'b0;
        while (!hit && n < maxc) begin
            @(posedge clk); #1;
            n++;
            hit = cond(which);
        end
        chk({tag, "_reached"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_beats(input int base, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_d [4];
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        chk("beat_count", 32'(bd.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("beat%0d_idx", k),  32'(bi[base+k]), 32'(k));
            chk($sformatf("beat%0d_data", k), 32'(bd[base+k]), 32'(exp_d[k]));
            chk($sformatf("beat%0d_last", k), 32'(bl[base+k]), 32'(k == 3));
        end
    endtask

    int b_er, b_ex, b_cv, b_rd, b_rp, b_bt, held_bad, n, s_conv, s_edges;
    logic s_prev;

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1; s_start = 1'b0;
        d1 = 8'hEE; d2 = 8'hEE; d3 = 8'hEE; d4 = 8'hEE;
        repeat (3) tick();
        chk("rst_controls", {27'd0, ERASE, EXPOSE, CONVERT, RAMP, READ}, 32'd0);
        chk("rst_stream", {20'd0, out_valid, out_last, busy, out_idx, out_data[6:0]}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Single frame with defaults; codes change when READ rises.
        b_er = erase_n; b_ex = expose_n; b_cv = conv_n; b_rd = read_n; b_rp = ramp_edges; b_bt = bd.size();
        pulse_start();
        chk("t1_erase_first", {31'd0, ERASE}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_for(1, 2000, "t1_read");
        d1 = 8'h7A; d2 = 8'h80; d3 = 8'h85; d4 = 8'h8A;
        wait_for(3, 50, "t1_idle");
        chk("t1_erase_cyc",  32'(erase_n - b_er), 32'd5);
        chk("t1_expose_cyc", 32'(expose_n - b_ex), 32'd255);
        chk("t1_convert_cyc", 32'(conv_n - b_cv), 32'd511);
        chk("t1_ramp_edges", 32'(ramp_edges - b_rp), 32'd255);
        chk("t1_read_cyc",   32'(read_n - b_rd), 32'd3);
        chk_beats(b_bt, 8'h7A, 8'h80, 8'h85, 8'h8A);
        chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("t1_valid_low", {31'd0, out_valid}, 32'd0);

        // Backpressure: hold idx 1 for 10 cycles.
        d1 = 8'h11; d2 = 8'h22; d3 = 8'h33; d4 = 8'h44;
        b_bt = bd.size();
        pulse_start();
        wait_for(0, 2000, "t2_valid");
        chk("t2_first_idx", 32'(out_idx), 32'd0);
        chk("t2_first_data", 32'(out_data), 32'h11);
        tick();
        out_ready = 1'b0;
        held_bad = 0;
        repeat (10) begin
            tick();
            if (out_idx !== 2'd1 || out_data !== 8'h22 || out_valid !== 1'b1) held_bad++;
        end
        chk("t2_stall_hold", 32'(held_bad), 32'd0);
        out_ready = 1'b1;
        wait_for(3, 20, "t2_idle");
        chk_beats(b_bt, 8'h11, 8'h22, 8'h33, 8'h44);
        chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        // Continuous mode for three frames.
        continuous = 1'b1;
        b_bt = bd.size();
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            wait_for(4, 2000, $sformatf("t3_last%0d", f));
            if (f == 2) continuous = 1'b0;
            tick();
            chk($sformatf("t3_frame_cnt%0d", f), {16'd0, frame_cnt}, 32'(3 + f));
            chk($sformatf("t3_erase_after%0d", f), {31'd0, ERASE}, 32'(f < 2));
            chk($sformatf("t3_busy_after%0d", f), {31'd0, busy}, 32'(f < 2));
        end
        chk("t3_beats", 32'(bd.size() - b_bt), 32'd12);
        chk("t3_onehot", 32'(onehot_err), 32'd0);

        // Reset mid-CONVERT, then a clean frame.
        ramp_goal = ramp_edges + 40;
        b_bt = bd.size();
        pulse_start();
        wait_for(5, 2000, "t4_ramp40");
        chk("t4_in_convert", {31'd0, CONVERT}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t4_async_controls", {27'd0, ERASE, EXPOSE, CONVERT, RAMP, READ}, 32'd0);
        chk("t4_async_stream", {29'd0, out_valid, out_last, busy}, 32'd0);
        chk("t4_async_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("t4_no_partial_beat", 32'(bd.size() - b_bt), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("t4_idle_after", {31'd0, busy}, 32'd0);
        d1 = 8'hEE; d2 = 8'hEE; d3 = 8'hEE; d4 = 8'hEE;
        b_rp = ramp_edges; b_bt = bd.size();
        pulse_start();
        wait_for(1, 2000, "t4_read");
        d1 = 8'h5C; d2 = 8'h63; d3 = 8'h6A; d4 = 8'h71;
        wait_for(3, 50, "t4_idle");
        chk("t4_ramp_edges", 32'(ramp_edges - b_rp), 32'd255);
        chk_beats(b_bt, 8'h5C, 8'h63, 8'h6A, 8'h71);
        chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // start during EXPOSE ignored; start at last beat chains a frame.
        pulse_start();
        wait_for(2, 50, "t5_expose");
        pulse_start();
        chk("t5_still_expose", {30'd0, EXPOSE, ERASE}, 32'd2);
        wait_for(4, 2000, "t5_last");
        pulse_start();
        chk("t5_frame_cnt1", {16'd0, frame_cnt}, 32'd2);
        chk("t5_restart_erase", {31'd0, ERASE}, 32'd1);
        wait_for(3, 2000, "t5_idle");
        chk("t5_frame_cnt2", {16'd0, frame_cnt}, 32'd3);
        repeat (5) tick();
        chk("t5_stays_idle", {31'd0, busy}, 32'd0);

        // Minimal-parameter instance: latency and short CONVERT.
        s_start = 1'b1;
        n = 0; s_conv = 0; s_edges = 0; s_prev = 1'b0;
        while (!s_out_valid && n < 50) begin
            tick();
            s_start = 1'b0;
            n++;
            if (s_CONVERT) s_conv++;
            if (s_RAMP && !s_prev) s_edges++;
            s_prev = s_RAMP;
        end
        chk("t6_latency", 32'(n), 32'd8);
        chk("t6_convert_cyc", 32'(s_conv), 32'd3);
        chk("t6_ramp_edges", 32'(s_edges), 32'd1);
        chk("t6_first_data", {22'd0, s_out_idx, s_out_data}, 32'h0A1);
        repeat (4) tick();
        chk("t6_frame_cnt", {16'd0, s_frame_cnt}, 32'd1);
        chk("t6_idle", {31'd0, s_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
